// File: rtl/rv_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Instruction classes, ALU operation codes, major opcodes and the NOP word.
package rv_enc_pkg;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_IALU   = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_LUI    = 3'd5,
        CLS_JAL    = 3'd6,
        CLS_RSVD   = 3'd7
    } instr_class_e;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SLL  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SRA  = 4'd6;
    localparam logic [3:0] ALU_OR   = 4'd7;
    localparam logic [3:0] ALU_AND  = 4'd8;
    localparam logic [3:0] ALU_SUB  = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_WIDTH = 33;

    function automatic logic [2:0] alu_func3(input logic [3:0] op);
        logic [2:0] f3;
        case (op)
            ALU_SLL:  f3 = 3'd1;
            ALU_SLT:  f3 = 3'd2;
            ALU_SLTU: f3 = 3'd3;
            ALU_XOR:  f3 = 3'd4;
            ALU_SRL:  f3 = 3'd5;
            ALU_SRA:  f3 = 3'd5;
            ALU_OR:   f3 = 3'd6;
            ALU_AND:  f3 = 3'd7;
            default:  f3 = 3'd0;
        endcase
        return f3;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and output handshake bundle of the instruction encoder.
// master = request producer / word consumer, slave = encoder.
interface instr_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_class;
    logic [3:0]  req_alu_op;
    logic [2:0]  req_func3;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_illegal;

    modport master (
        output req_valid, req_class, req_alu_op, req_func3, req_rd, req_rs1, req_rs2, req_imm,
        output out_ready,
        input  req_ready, out_valid, out_instr, out_illegal
    );

    modport slave (
        input  req_valid, req_class, req_alu_op, req_func3, req_rd, req_rs1, req_rs2, req_imm,
        input  out_ready,
        output req_ready, out_valid, out_instr, out_illegal
    );
endinterface

// File: rtl/enc_fifo.sv
// Two-entry buffer of {illegal, instr} words; head is visible straight from storage.
module enc_fifo
    import rv_enc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [FIFO_WIDTH-1:0] din,
    output logic [FIFO_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    logic [FIFO_WIDTH-1:0] mem_reg [FIFO_DEPTH];
    logic                  wr_ptr_reg;
    logic                  rd_ptr_reg;
    logic [1:0]            count_reg;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count_reg == 2'd2);
    assign empty   = (count_reg == 2'd0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_reg[wr_ptr_reg] <= din;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (pop_ok) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: combinational encode into a 2-entry output buffer,
// illegal requests become a flagged NOP; counts legal and illegal accepts.
module instr_encoder
    import rv_enc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    instr_encoder_if.slave        bus,
    output logic [15:0]           enc_count,
    output logic [7:0]            err_count
);
    instr_class_e          cls;
    logic [31:0]           enc_word;
    logic                  enc_illegal;
    logic [2:0]            f3_alu;
    logic [6:0]            f7_alu;
    logic                  is_shift;
    logic [3:0]            op;
    logic [31:0]           imm;

    logic                  req_ready_reg;
    logic [15:0]           enc_count_reg;
    logic [7:0]            err_count_reg;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_WIDTH-1:0] fifo_dout;
    logic [1:0]            occ;
    logic [1:0]            occ_next;

    assign cls      = instr_class_e'(bus.req_class);
    assign op       = bus.req_alu_op;
    assign imm      = bus.req_imm;
    assign f3_alu   = alu_func3(op);
    assign f7_alu   = (op == ALU_SUB || op == ALU_SRA) ? 7'b0100000 : 7'b0000000;
    assign is_shift = (op == ALU_SLL || op == ALU_SRL || op == ALU_SRA);

    always_comb begin
        enc_word    = NOP_INSTR;
        enc_illegal = 1'b0;
        case (cls)
            CLS_R: begin
                if (op > ALU_SUB) enc_illegal = 1'b1;
                else enc_word = {f7_alu, bus.req_rs2, bus.req_rs1, f3_alu, bus.req_rd, OPC_OP};
            end
            CLS_IALU: begin
                if (op >= ALU_SUB) enc_illegal = 1'b1;
                else if (is_shift)
                    enc_word = {f7_alu, imm[4:0], bus.req_rs1, f3_alu, bus.req_rd, OPC_OP_IMM};
                else
                    enc_word = {imm[11:0], bus.req_rs1, f3_alu, bus.req_rd, OPC_OP_IMM};
            end
            CLS_LOAD: begin
                if (bus.req_func3 == 3'd3 || bus.req_func3 >= 3'd6) enc_illegal = 1'b1;
                else enc_word = {imm[11:0], bus.req_rs1, bus.req_func3, bus.req_rd, OPC_LOAD};
            end
            CLS_STORE: begin
                if (bus.req_func3 > 3'd2) enc_illegal = 1'b1;
                else enc_word = {imm[11:5], bus.req_rs2, bus.req_rs1, bus.req_func3,
                                 imm[4:0], OPC_STORE};
            end
            CLS_BRANCH: begin
                if (bus.req_func3 == 3'd2 || bus.req_func3 == 3'd3 || imm[0]) enc_illegal = 1'b1;
                else enc_word = {imm[12], imm[10:5], bus.req_rs2, bus.req_rs1, bus.req_func3,
                                 imm[4:1], imm[11], OPC_BRANCH};
            end
            CLS_LUI: enc_word = {imm[31:12], bus.req_rd, OPC_LUI};
            CLS_JAL: begin
                if (imm[0]) enc_illegal = 1'b1;
                else enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.req_rd, OPC_JAL};
            end
            default: enc_illegal = 1'b1;
        endcase
        if (enc_illegal) enc_word = NOP_INSTR;
    end

    assign push     = bus.req_valid && req_ready_reg;
    assign pop      = bus.out_valid && bus.out_ready;
    assign occ      = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    assign occ_next = occ + 2'(push) - 2'(pop);

    // Ready looks at next-cycle occupancy so out_ready never reaches req_ready combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready_reg <= 1'b0;
            enc_count_reg <= 16'd0;
            err_count_reg <= 8'd0;
        end else begin
            req_ready_reg <= (occ_next < 2'd2);
            if (push) begin
                if (enc_illegal) begin
                    if (err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
                end else begin
                    enc_count_reg <= enc_count_reg + 16'd1;
                end
            end
        end
    end

    enc_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({enc_illegal, enc_word}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.req_ready   = req_ready_reg;
    assign bus.out_valid   = !fifo_empty;
    assign bus.out_instr   = fifo_dout[31:0];
    assign bus.out_illegal = fifo_dout[32];
    assign enc_count       = enc_count_reg;
    assign err_count       = err_count_reg;
endmodule
